axis_align_arb: RTL and testbench

//   Round-robin packet arbiter sharing one axis_align datapath among NUM_PORTS AXI-Stream sources.

---
 rtl/axis_align_arb.sv | 155 +++++++++++++++
 tb/tb_axis_align_arb.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_align_arb.sv
// Round-robin packet arbiter feeding axis_align through a 2-entry skid buffer.
// One source is locked from its first beat to its tlast beat; s_axis_tready is registered.
module axis_align_arb #(
   parameter int AXIS_DW   = 64,
   parameter int NUM_PORTS = 4,
   parameter int CNT_W     = 16,
   localparam int AXIS_KW  = ((AXIS_DW - 1) >> 3) + 1,
   localparam int IDW      = $clog2(NUM_PORTS)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_PORTS-1:0]           port_en,
   input  logic [NUM_PORTS-1:0]           s_axis_tvalid,
   output logic [NUM_PORTS-1:0]           s_axis_tready,
   input  logic [NUM_PORTS*AXIS_DW-1:0]   s_axis_tdata,
   input  logic [NUM_PORTS*AXIS_KW-1:0]   s_axis_tkeep,
   input  logic [NUM_PORTS-1:0]           s_axis_tlast,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic [AXIS_DW-1:0]             m_axis_tdata,
   output logic [AXIS_KW-1:0]             m_axis_tkeep,
   output logic                           m_axis_tlast,
   output logic [IDW-1:0]                 m_axis_tid,
   output logic [CNT_W-1:0]               pkt_cnt
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t               state_q, state_d;
   logic [IDW-1:0]       grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick;
   logic                 pick_valid;
   logic [NUM_PORTS-1:0] req, ready_q, ready_d;
   logic [CNT_W-1:0]     pkt_cnt_q;

   logic [AXIS_DW-1:0]   sel_data;
   logic [AXIS_KW-1:0]   sel_keep;
   logic                 sel_last;
   logic                 take, take_last;

   logic [AXIS_DW-1:0]   buf_data [2];
   logic [AXIS_KW-1:0]   buf_keep [2];
   logic                 buf_last [2];
   logic [IDW-1:0]       buf_id   [2];
   logic                 wr_ptr, rd_ptr;
   logic [1:0]           count_q, count_d;
   logic                 pop, stall, skid_full;

   assign req       = s_axis_tvalid & port_en;
   assign sel_data  = s_axis_tdata[int'(grant_q)*AXIS_DW +: AXIS_DW];
   assign sel_keep  = s_axis_tkeep[int'(grant_q)*AXIS_KW +: AXIS_KW];
   assign sel_last  = s_axis_tlast[grant_q];
   assign take      = (state_q == BUSY) && ready_q[grant_q] && s_axis_tvalid[grant_q];
   assign take_last = take && sel_last;

   assign m_axis_tvalid = (count_q != 2'd0);
   assign pop           = m_axis_tvalid && m_axis_tready;
   assign stall         = m_axis_tvalid && !m_axis_tready;

   // Scan from the port after the last winner so every requester gets a turn.
   always_comb begin
      int idx;
      logic [IDW-1:0] cand;
      pick       = '0;
      pick_valid = 1'b0;
      idx        = 0;
      cand       = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         cand = IDW'(idx);
         if (!pick_valid && req[cand]) begin
            pick_valid = 1'b1;
            pick       = cand;
         end
      end
   end

   always_comb begin
      count_d = count_q;
      if (take && !pop)      count_d = count_q + 2'd1;
      else if (!take && pop) count_d = count_q - 2'd1;
   end

   // A stalled single entry counts as full so a push never meets a full buffer.
   assign skid_full = (count_d == 2'd2) || ((count_d == 2'd1) && stall);

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      ready_d  = '0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d  = pick;
               rr_ptr_d = pick;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (take_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if ((state_d == BUSY) && !skid_full) ready_d[grant_d] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= IDW'(NUM_PORTS - 1);
         ready_q   <= '0;
         pkt_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         ready_q  <= ready_d;
         if (take_last) pkt_cnt_q <= pkt_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            buf_data[i] <= '0;
            buf_keep[i] <= '0;
            buf_last[i] <= 1'b0;
            buf_id[i]   <= '0;
         end
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (take) begin
            buf_data[wr_ptr] <= sel_data;
            buf_keep[wr_ptr] <= sel_keep;
            buf_last[wr_ptr] <= sel_last;
            buf_id[wr_ptr]   <= grant_q;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count_q <= count_d;
      end
   end

   assign s_axis_tready = ready_q;
   assign m_axis_tdata  = buf_data[rd_ptr];
   assign m_axis_tkeep  = buf_keep[rd_ptr];
   assign m_axis_tlast  = buf_last[rd_ptr];
   assign m_axis_tid    = buf_id[rd_ptr];
   assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_axis_align_arb.sv
// Self-checking bench for axis_align_arb: arbitration vector table, directed corner
// sequences, and a randomized run against a per-port scoreboard and round-robin model.
`timescale 1ns/1ps
module tb_axis_align_arb;
   localparam int DW = 64;
   localparam int KW = 8;
   localparam int NP = 4;
   localparam int IW = 2;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic [NP-1:0]    port_en, s_tvalid, s_tready, s_tlast;
   logic [NP*DW-1:0] s_tdata;
   logic [NP*KW-1:0] s_tkeep;
   logic             m_tvalid, m_tready, m_tlast;
   logic [DW-1:0]    m_tdata;
   logic [KW-1:0]    m_tkeep;
   logic [IW-1:0]    m_tid;
   logic [CW-1:0]    pkt_cnt;

   always #5 clk = ~clk;

   axis_align_arb #(.AXIS_DW(DW), .NUM_PORTS(NP), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .port_en(port_en),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
      .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
      .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
      .pkt_cnt(pkt_cnt)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      int            id;
   } obeat_t;

   typedef struct {
      logic [NP-1:0] en;
      logic [NP-1:0] vld;
      logic [NP-1:0] expRdy;
   } vec_t;

   int     checks = 0;
   int     failures = 0;
   beat_t  srcQ [NP][$];
   beat_t  expQ [NP][$];
   obeat_t outLog [$];
   int     accCnt = 0;
   int     gapPct = 0;
   bit     randReady = 1'b0;
   int     pushedPkts = 0;

   bit          modelIdle = 1'b1;
   int          modelLast = NP - 1;
   int          modelGrant = 0;
   int          modelCnt = 0;
   bit          prevStall = 1'b0;
   logic [75:0] prevFields = '0;
   bit          lockValid = 1'b0;
   int          lockId = 0;

   function automatic void checkOutput(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endfunction

   function automatic int rrPick(int last, logic [NP-1:0] r);
      for (int i = 1; i <= NP; i++)
         if (r[(last + i) % NP]) return (last + i) % NP;
      return -1;
   endfunction

   // Advance one clock: retire accepted beats, then present the next beat of each source.
   task automatic applyStimulus();
      logic [NP-1:0] hs;
      hs = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
         if (hs[p] && srcQ[p].size() != 0) begin
            void'(srcQ[p].pop_front());
            accCnt++;
         end
         if (!(s_tvalid[p] && !hs[p])) begin
            if (srcQ[p].size() != 0 && $urandom_range(99) >= gapPct) begin
               s_tvalid[p]           = 1'b1;
               s_tdata[p*DW +: DW]   = srcQ[p][0].data;
               s_tkeep[p*KW +: KW]   = srcQ[p][0].keep;
               s_tlast[p]            = srcQ[p][0].last;
            end else begin
               s_tvalid[p] = 1'b0;
            end
         end
      end
      if (randReady) m_tready = ($urandom_range(3) != 0);
   endtask

   task automatic pushPacket(int p, int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = {$urandom, $urandom};
         b.last = (i == len - 1);
         b.keep = b.last ? 8'($urandom_range(1, 255)) : 8'hFF;
         srcQ[p].push_back(b);
      end
      pushedPkts++;
   endtask

   task automatic doReset();
      rst_n    = 1'b0;
      s_tvalid = '0;
      for (int p = 0; p < NP; p++) srcQ[p].delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      outLog.delete();
      pushedPkts = 0;
   endtask

   task automatic drain(string name, int budget);
      bit done;
      done = 1'b0;
      for (int n = 0; n < budget && !done; n++) begin
         applyStimulus();
         done = (srcQ[0].size() + srcQ[1].size() + srcQ[2].size() + srcQ[3].size() == 0)
                && (s_tvalid == '0) && !m_tvalid;
      end
      checkOutput(name, done, 1);
   endtask

   task automatic waitAccepted(string name, int n, int budget);
      int a0;
      a0 = accCnt;
      for (int i = 0; i < budget && (accCnt - a0) < n; i++) applyStimulus();
      checkOutput(name, (accCnt - a0) >= n, 1);
   endtask

   // Monitor: scoreboard, round-robin model, output hold and packet lock checks.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int p = 0; p < NP; p++) expQ[p].delete();
         modelIdle = 1'b1;
         modelLast = NP - 1;
         modelCnt  = 0;
         prevStall = 1'b0;
         lockValid = 1'b0;
      end else begin
         checkOutput("pkt_cnt", pkt_cnt, CW'(modelCnt));
         if (prevStall)
            checkOutput("out_hold", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid}, prevFields);
         prevStall  = m_tvalid && !m_tready;
         prevFields = {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid};
         if (s_tready != '0)
            checkOutput("rdy_grant", s_tready, modelIdle ? '0 : (128'(1) << modelGrant));
         if (modelIdle && (s_tvalid & port_en) != '0) begin
            modelGrant = rrPick(modelLast, s_tvalid & port_en);
            modelLast  = modelGrant;
            modelIdle  = 1'b0;
         end
         for (int p = 0; p < NP; p++) begin
            if (s_tready[p] && s_tvalid[p]) begin
               expQ[p].push_back('{data: s_tdata[p*DW +: DW], keep: s_tkeep[p*KW +: KW],
                                   last: s_tlast[p]});
               if (s_tlast[p]) begin
                  modelCnt++;
                  modelIdle = 1'b1;
               end
            end
         end
         if (m_tvalid && m_tready) begin
            beat_t e;
            outLog.push_back('{data: m_tdata, last: m_tlast, id: int'(m_tid)});
            checkOutput("beat_avail", expQ[m_tid].size() != 0, 1);
            if (expQ[m_tid].size() != 0) begin
               e = expQ[m_tid].pop_front();
               checkOutput("beat", {m_tdata, m_tkeep, m_tlast}, {e.data, e.keep, e.last});
            end
            if (lockValid) checkOutput("no_interleave", m_tid, lockId);
            lockValid = !m_tlast;
            lockId    = int'(m_tid);
         end
      end
   end

   initial begin
      vec_t vecs [15];
      int   grants;
      int   c1;
      bit   early;
      int   expOrder [8];

      vecs[0]  = '{4'hF, 4'h1, 4'h1};
      vecs[1]  = '{4'hF, 4'hF, 4'h2};
      vecs[2]  = '{4'hF, 4'hF, 4'h4};
      vecs[3]  = '{4'hF, 4'hF, 4'h8};
      vecs[4]  = '{4'hF, 4'hF, 4'h1};
      vecs[5]  = '{4'hD, 4'hF, 4'h4};
      vecs[6]  = '{4'hD, 4'hF, 4'h8};
      vecs[7]  = '{4'hD, 4'hF, 4'h1};
      vecs[8]  = '{4'hD, 4'hF, 4'h4};
      vecs[9]  = '{4'hF, 4'h3, 4'h1};
      vecs[10] = '{4'hF, 4'hA, 4'h2};
      vecs[11] = '{4'h7, 4'h8, 4'h0};
      vecs[12] = '{4'hF, 4'h8, 4'h8};
      vecs[13] = '{4'hF, 4'h5, 4'h1};
      vecs[14] = '{4'hF, 4'h5, 4'h4};

      port_en  = 4'hF;
      s_tvalid = '0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = '0;
      m_tready = 1'b1;
      rst_n    = 1'b0;
      #1;
      checkOutput("rst_tready", s_tready, 0);
      checkOutput("rst_tvalid", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid}, 0);
      checkOutput("rst_pkt_cnt", pkt_cnt, 0);
      doReset();

      // Arbitration vector table: one single-beat packet per row, pointer carries over.
      grants = 0;
      for (int i = 0; i < 15; i++) begin
         port_en = vecs[i].en;
         for (int p = 0; p < NP; p++)
            if (vecs[i].vld[p]) pushPacket(p, 1);
         for (int n = 0; n < 4 && s_tready == '0; n++) applyStimulus();
         checkOutput($sformatf("vec%0d_rdy", i), s_tready, vecs[i].expRdy);
         if (vecs[i].expRdy != '0) begin
            applyStimulus();
            grants++;
            checkOutput($sformatf("vec%0d_tid", i), {m_tvalid, m_tlast, m_tid},
                        {1'b1, 1'b1, IW'($clog2(vecs[i].expRdy))});
         end
         for (int p = 0; p < NP; p++) srcQ[p].delete();
         s_tvalid = '0;
      end
      applyStimulus();
      checkOutput("vec_pkt_cnt", pkt_cnt, grants);

      // Single port, 4-beat packet: ready one cycle after valid, in order, tlast last.
      port_en = 4'hF;
      doReset();
      pushPacket(0, 4);
      applyStimulus();
      checkOutput("t1_rdy_wait", s_tready, 0);
      applyStimulus();
      checkOutput("t1_rdy", s_tready, 4'h1);
      drain("t1_drain", 40);
      checkOutput("t1_beats", outLog.size(), 4);
      for (int i = 0; i < outLog.size(); i++)
         checkOutput($sformatf("t1_beat%0d", i), {outLog[i].id, outLog[i].last}, {32'd0, i == 3});
      checkOutput("t1_pkt_cnt", pkt_cnt, 1);

      // All ports request together: strict rotation 0,1,2,3,0,...
      doReset();
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < NP; p++) pushPacket(p, 1);
      drain("t2_drain", 60);
      checkOutput("t2_count", outLog.size(), 8);
      for (int i = 0; i < outLog.size() && i < 8; i++)
         checkOutput($sformatf("t2_order%0d", i), outLog[i].id, i % NP);
      checkOutput("t2_pkt_cnt", pkt_cnt, 8);

      // Packet lock: port 0 cannot break into port 1's packet; next grant is 2 then 0.
      doReset();
      pushPacket(1, 6);
      waitAccepted("t3_wait", 2, 20);
      pushPacket(0, 1);
      pushPacket(2, 1);
      early = 1'b0;
      for (int n = 0; n < 40 && srcQ[1].size() != 0; n++) begin
         applyStimulus();
         if (s_tready[0]) early = 1'b1;
      end
      checkOutput("t3_p0_blocked", early, 0);
      drain("t3_drain", 40);
      expOrder = '{1, 1, 1, 1, 1, 1, 2, 0};
      checkOutput("t3_count", outLog.size(), 8);
      for (int i = 0; i < outLog.size() && i < 8; i++)
         checkOutput($sformatf("t3_order%0d", i), outLog[i].id, expOrder[i]);

      // Output stall during a 10-beat packet: ready drops, data held, nothing lost.
      doReset();
      pushPacket(0, 10);
      repeat (4) applyStimulus();
      m_tready = 1'b0;
      begin
         int a0;
         a0 = accCnt;
         repeat (5) applyStimulus();
         checkOutput("t4_stall_rdy", s_tready, 0);
         checkOutput("t4_stall_acc_le2", (accCnt - a0) <= 2, 1);
      end
      m_tready = 1'b1;
      drain("t4_drain", 60);
      checkOutput("t4_beats", outLog.size(), 10);

      // Masked port never wins; disabling a port mid-packet does not cut the packet.
      doReset();
      port_en = 4'hD;
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < NP; p++) pushPacket(p, 1);
      repeat (40) applyStimulus();
      c1 = 0;
      foreach (outLog[i]) if (outLog[i].id == 1) c1++;
      checkOutput("t5_p1_masked", c1, 0);
      checkOutput("t5_count", outLog.size(), 6);
      port_en = 4'hF;
      doReset();
      pushPacket(2, 4);
      waitAccepted("t5_wait", 2, 20);
      port_en = 4'hB;
      drain("t5_drain", 40);
      checkOutput("t5_p2_beats", outLog.size(), 4);
      c1 = 0;
      foreach (outLog[i]) if (outLog[i].id == 2) c1++;
      checkOutput("t5_p2_tid", c1, 4);
      checkOutput("t5_pkt_cnt", pkt_cnt, 1);
      port_en = 4'hF;

      // Reset mid-packet clears everything and restarts arbitration at port 0.
      doReset();
      pushPacket(0, 1);
      drain("t6_pre", 30);
      checkOutput("t6_pre_cnt", pkt_cnt, 1);
      pushPacket(1, 5);
      waitAccepted("t6_wait", 1, 20);
      rst_n    = 1'b0;
      s_tvalid = '0;
      for (int p = 0; p < NP; p++) srcQ[p].delete();
      #1;
      checkOutput("t6_rst_async", {m_tvalid, s_tready, pkt_cnt}, 0);
      @(posedge clk);
      #1;
      checkOutput("t6_rst_edge", {m_tvalid, s_tready, pkt_cnt}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      outLog.delete();
      pushPacket(0, 1);
      pushPacket(2, 1);
      drain("t6_post", 30);
      checkOutput("t6_post_count", outLog.size(), 2);
      if (outLog.size() != 0) checkOutput("t6_first_grant", outLog[0].id, 0);

      // Randomized traffic with gaps, back-pressure and port_en changes.
      doReset();
      gapPct    = 30;
      randReady = 1'b1;
      for (int cyc = 0; cyc < 6000; cyc++) begin
         for (int p = 0; p < NP; p++)
            if (srcQ[p].size() < 6 && $urandom_range(3) == 0) pushPacket(p, $urandom_range(1, 5));
         if ($urandom_range(39) == 0) port_en = 4'($urandom);
         applyStimulus();
      end
      gapPct    = 0;
      randReady = 1'b0;
      m_tready  = 1'b1;
      port_en   = 4'hF;
      drain("rand_drain", 4000);
      checkOutput("rand_lost", expQ[0].size() + expQ[1].size() + expQ[2].size() + expQ[3].size(), 0);
      checkOutput("rand_pkts", pkt_cnt, CW'(pushedPkts));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
